// File: rtl/event_fifo_pkg.sv
// ----------------------------------------------------------------------------
// event_fifo_pkg : shared sizes and types for the event FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package event_fifo_pkg;

   localparam int EF_WIDTH     = 64;
   localparam int EF_FIFO_BITS = 11;
   localparam int DEPTH        = 2 ** EF_FIFO_BITS;
   localparam int HALF_THRESH  = DEPTH / 2;

   typedef logic [EF_WIDTH-2:0]  event_word_t;
   typedef logic [EF_FIFO_BITS:0] fifo_count_t;

endpackage

`default_nettype wire

// File: rtl/event_fifo_ram.sv
// ----------------------------------------------------------------------------
// event_fifo_ram : DEPTH x (WIDTH-1) RAM, one write port, one registered read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module event_fifo_ram
   import event_fifo_pkg::*;
#(
   parameter int WIDTH     = EF_WIDTH,
   parameter int FIFO_BITS = EF_FIFO_BITS
) (
   input  logic                 clk,
   input  logic                 wr_en_i,
   input  logic [FIFO_BITS-1:0] wr_addr_i,
   input  logic [WIDTH-2:0]     wr_data_i,
   input  logic                 rd_en_i,
   input  logic [FIFO_BITS-1:0] rd_addr_i,
   output logic [WIDTH-2:0]     rd_data_o
);

   logic [WIDTH-2:0] mem_q [2**FIFO_BITS];
   logic [WIDTH-2:0] rd_data_q;

   // No reset on the array so a vendor macro can drop in here unchanged.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/event_fifo.sv
// ----------------------------------------------------------------------------
// event_fifo : FWFT event FIFO with two-entry output stage, status and sticky errors
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module event_fifo
   import event_fifo_pkg::*;
#(
   parameter int WIDTH     = EF_WIDTH,
   parameter int FIFO_BITS = EF_FIFO_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-2:0]     pre_event,
   input  logic                 write_fifo_n,
   input  logic                 read_fifo_n,
   input  logic                 clear_errors,
   output logic [WIDTH-2:0]     tx_data,
   output logic                 fifo_empty,
   output logic                 fifo_half,
   output logic                 fifo_full,
   output logic [FIFO_BITS:0]   fifo_counter,
   output logic                 fifo_overflow,
   output logic                 fifo_underflow
);

   localparam int CNT_W = FIFO_BITS + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {FIFO_BITS{1'b0}}};
   localparam logic [CNT_W-1:0] HALF_C  = {2'b01, {(FIFO_BITS-1){1'b0}}};

   logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, ram_cnt_q, ram_cnt_d;
   logic [WIDTH-2:0]     head_q, head_d, skid_q, skid_d;
   logic                 head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
   logic                 rd_pend_q;
   logic                 empty_q, full_q, half_q, ovf_q, ovf_d, udf_q, udf_d;
   logic [WIDTH-2:0]     ram_rdata;
   logic [1:0]           slots_used;
   logic                 push, pop, rd_issue;

   assign push = !write_fifo_n && !full_q;
   assign pop  = !read_fifo_n && head_vld_q;

   // A read is only launched when a stage slot is guaranteed for its data one cycle later.
   assign slots_used = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q);
   assign rd_issue   = (ram_cnt_q != '0) && ((slots_used - 2'(pop)) < 2'd2);

   assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
   assign ram_cnt_d = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_issue);
   assign wptr_d    = wptr_q + FIFO_BITS'(push);
   assign rptr_d    = rptr_q + FIFO_BITS'(rd_issue);
   assign ovf_d     = (ovf_q && !clear_errors) || (!write_fifo_n && full_q);
   assign udf_d     = (udf_q && !clear_errors) || (!read_fifo_n && !head_vld_q);

   always_comb begin
      head_d     = head_q;
      skid_d     = skid_q;
      head_vld_d = head_vld_q;
      skid_vld_d = skid_vld_q;
      if (pop) begin
         if (skid_vld_q) begin
            head_d     = skid_q;
            skid_vld_d = rd_pend_q;
            if (rd_pend_q) skid_d = ram_rdata;
         end else begin
            head_vld_d = rd_pend_q;
            skid_vld_d = 1'b0;
            if (rd_pend_q) head_d = ram_rdata;
         end
      end else if (rd_pend_q) begin
         if (head_vld_q) begin
            skid_d     = ram_rdata;
            skid_vld_d = 1'b1;
         end else begin
            head_d     = ram_rdata;
            head_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         ram_cnt_q  <= '0;
         head_q     <= '0;
         skid_q     <= '0;
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         half_q     <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         ram_cnt_q  <= ram_cnt_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         rd_pend_q  <= rd_issue;
         empty_q    <= !head_vld_d;
         full_q     <= (cnt_d == DEPTH_C);
         half_q     <= (cnt_d >= HALF_C);
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   event_fifo_ram #(
      .WIDTH     (WIDTH),
      .FIFO_BITS (FIFO_BITS)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (push),
      .wr_addr_i (wptr_q),
      .wr_data_i (pre_event),
      .rd_en_i   (rd_issue),
      .rd_addr_i (rptr_q),
      .rd_data_o (ram_rdata)
   );

   assign tx_data        = head_q;
   assign fifo_empty     = empty_q;
   assign fifo_half      = half_q;
   assign fifo_full      = full_q;
   assign fifo_counter   = cnt_q;
   assign fifo_overflow  = ovf_q;
   assign fifo_underflow = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_event_fifo.sv
// ----------------------------------------------------------------------------
// tb_event_fifo : vector table plus scoreboard-driven sequences for event_fifo
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_event_fifo;
   import event_fifo_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   event_word_t pre_event, tx_data;
   logic        write_fifo_n, read_fifo_n, clear_errors;
   logic        fifo_empty, fifo_half, fifo_full, fifo_overflow, fifo_underflow;
   fifo_count_t fifo_counter;

   int          n_chk  = 0;
   int          n_fail = 0;
   event_word_t sb[$];
   int          mcnt;
   bit          movf, mund;

   typedef struct {
      bit          wr;
      bit          rd;
      bit          clr;
      event_word_t din;
      int          cnt;
      bit          empty;
      bit          chk_tx;
      event_word_t tx;
      bit          ovf;
      bit          udf;
   } vec_t;

   vec_t vt[13];

   always #5 clk = ~clk;

   event_fifo dut (
      .clk            (clk),
      .reset          (reset),
      .pre_event      (pre_event),
      .write_fifo_n   (write_fifo_n),
      .read_fifo_n    (read_fifo_n),
      .clear_errors   (clear_errors),
      .tx_data        (tx_data),
      .fifo_empty     (fifo_empty),
      .fifo_half      (fifo_half),
      .fifo_full      (fifo_full),
      .fifo_counter   (fifo_counter),
      .fifo_overflow  (fifo_overflow),
      .fifo_underflow (fifo_underflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      write_fifo_n = 1'b1;
      read_fifo_n  = 1'b1;
      clear_errors = 1'b0;
      pre_event    = '0;
   endtask

   // One clock of stimulus; the scoreboard and flag model advance before the edge.
   task automatic cyc(input bit wr, input event_word_t w, input bit rd, input bit clr);
      bit did_push, did_pop;
      write_fifo_n = ~wr;
      read_fifo_n  = ~rd;
      pre_event    = w;
      clear_errors = clr;
      did_pop  = rd && !fifo_empty;
      did_push = wr && (mcnt < DEPTH);
      if (did_pop) begin
         if (sb.size() == 0) chk("sb_underrun", 64'd1, 64'd0);
         else                chk("pop_data", 64'(tx_data), 64'(sb.pop_front()));
      end
      movf = (movf && !clr) || (wr && mcnt == DEPTH);
      mund = (mund && !clr) || (rd && fifo_empty);
      if (did_push) sb.push_back(w);
      mcnt = mcnt + int'(did_push) - int'(did_pop);
      @(posedge clk);
      #1;
      chk("counter",   64'(fifo_counter),   64'(mcnt));
      chk("full",      64'(fifo_full),      64'(mcnt == DEPTH));
      chk("half",      64'(fifo_half),      64'(mcnt >= HALF_THRESH));
      chk("overflow",  64'(fifo_overflow),  64'(movf));
      chk("underflow", 64'(fifo_underflow), 64'(mund));
      idle_inputs();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_tx"},    64'(tx_data),        64'd0);
      chk({tag, "_cnt"},   64'(fifo_counter),   64'd0);
      chk({tag, "_empty"}, 64'(fifo_empty),     64'd1);
      chk({tag, "_half"},  64'(fifo_half),      64'd0);
      chk({tag, "_full"},  64'(fifo_full),      64'd0);
      chk({tag, "_ovf"},   64'(fifo_overflow),  64'd0);
      chk({tag, "_udf"},   64'(fifo_underflow), 64'd0);
   endtask

   task automatic drain_all(input string tag);
      for (int k = 0; k < DEPTH; k++) begin
         chk({tag, "_no_bubble"}, 64'(fifo_empty), 64'd0);
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      chk({tag, "_empty_end"}, 64'(fifo_empty), 64'd1);
      chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      // rows: wr rd clr din | cnt empty chk_tx tx ovf udf   (row k = edge k+1)
      vt[0]  = '{1, 0, 0, 63'h1234,        1, 1, 0, 63'h0,           0, 0};
      vt[1]  = '{0, 0, 0, 63'h0,           1, 1, 0, 63'h0,           0, 0};
      vt[2]  = '{0, 0, 0, 63'h0,           1, 0, 1, 63'h1234,        0, 0};
      vt[3]  = '{0, 1, 0, 63'h0,           0, 1, 1, 63'h1234,        0, 0};
      vt[4]  = '{0, 1, 0, 63'h0,           0, 1, 0, 63'h0,           0, 1};
      vt[5]  = '{0, 0, 1, 63'h0,           0, 1, 0, 63'h0,           0, 0};
      vt[6]  = '{1, 1, 1, 63'h0AAA_0001,   1, 1, 0, 63'h0,           0, 1};
      vt[7]  = '{1, 0, 0, 63'h0BBB_0002,   2, 1, 0, 63'h0,           0, 1};
      vt[8]  = '{0, 0, 0, 63'h0,           2, 0, 1, 63'h0AAA_0001,   0, 1};
      vt[9]  = '{1, 1, 0, 63'h0CCC_0003,   2, 0, 1, 63'h0BBB_0002,   0, 1};
      vt[10] = '{0, 1, 0, 63'h0,           1, 1, 1, 63'h0BBB_0002,   0, 1};
      vt[11] = '{0, 0, 0, 63'h0,           1, 0, 1, 63'h0CCC_0003,   0, 1};
      vt[12] = '{0, 1, 0, 63'h0,           0, 1, 1, 63'h0CCC_0003,   0, 1};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst");
      reset = 1'b0;

      foreach (vt[i]) begin
         write_fifo_n = ~vt[i].wr;
         read_fifo_n  = ~vt[i].rd;
         clear_errors = vt[i].clr;
         pre_event    = vt[i].din;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_cnt", i),   64'(fifo_counter),   64'(vt[i].cnt));
         chk($sformatf("vec%0d_empty", i), 64'(fifo_empty),     64'(vt[i].empty));
         chk($sformatf("vec%0d_ovf", i),   64'(fifo_overflow),  64'(vt[i].ovf));
         chk($sformatf("vec%0d_udf", i),   64'(fifo_underflow), 64'(vt[i].udf));
         if (vt[i].chk_tx) chk($sformatf("vec%0d_tx", i), 64'(tx_data), 64'(vt[i].tx));
         idle_inputs();
      end

      mcnt = 0;
      movf = 1'b0;
      mund = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Fill to full, then one push too many.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, event_word_t'(i), 1'b0, 1'b0);
      cyc(1'b1, 63'h7FF_DEAD, 1'b0, 1'b0);
      chk("full_ovf_cnt", 64'(fifo_counter), 64'(DEPTH));
      chk("full_ovf_flag", 64'(fifo_overflow), 64'd1);
      drain_all("drain1");
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Second fill/drain crosses the pointer wrap.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, event_word_t'(63'h5A5A_0000 + i), 1'b0, 1'b0);
      drain_all("drain2");

      // Steady simultaneous push/pop with 10 words held.
      for (int i = 0; i < 10; i++) cyc(1'b1, event_word_t'(100 + i), 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b1, event_word_t'(1000 + i), 1'b1, 1'b0);
         chk("steady_cnt", 64'(fifo_counter), 64'd10);
      end
      for (int k = 0; k < 40 && mcnt > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("steady_drained", 64'(sb.size()), 64'd0);

      // Underflow and its clear.
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("udf_set", 64'(fifo_underflow), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("udf_clr", 64'(fifo_underflow), 64'd0);
      chk("udf_cnt", 64'(fifo_counter), 64'd0);

      // Asynchronous reset in the middle of a 500-word backlog.
      for (int i = 0; i < 500; i++) cyc(1'b1, event_word_t'(63'h3000 + i), 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("arst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      mcnt = 0;
      movf = 1'b0;
      mund = 1'b0;
      cyc(1'b1, 63'h0ABC_DEF0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("post_rst_tx", 64'(tx_data), 64'h0ABC_DEF0);
      chk("post_rst_empty", 64'(fifo_empty), 64'd0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_empty_end", 64'(fifo_empty), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
